// File: rtl/soc_picorv32_xbar.sv
// PicoRV32 native-bus crossbar: BRAM/SPRAM on the low half, up to 16 Wishbone slaves on the high half.
// Wishbone side runs a single outstanding transaction with timeout and sticky first-error capture.
module soc_picorv32_xbar #(
  parameter int          WB_N     = 8,
  parameter int          WB_DW    = 32,
  parameter int          WB_AW    = 16,
  parameter int          WB_AI    = 2,
  parameter int          RAM_AW   = 15,
  parameter int          TO_W     = 8,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              pb_addr,
  input  logic [31:0]              pb_wdata,
  input  logic [3:0]               pb_wstrb,
  input  logic                     pb_valid,
  output logic [31:0]              pb_rdata,
  output logic                     pb_ready,
  output logic [RAM_AW-1:0]        bram_addr,
  output logic [31:0]              bram_wdata,
  output logic [3:0]               bram_wmsk,
  output logic                     bram_we,
  input  logic [31:0]              bram_rdata,
  output logic [RAM_AW-1:0]        spram_addr,
  output logic [31:0]              spram_wdata,
  output logic [3:0]               spram_wmsk,
  output logic                     spram_we,
  input  logic [31:0]              spram_rdata,
  output logic [WB_AW-1:0]         wb_addr,
  output logic [WB_DW-1:0]         wb_wdata,
  output logic [WB_DW/8-1:0]       wb_wmsk,
  output logic                     wb_we,
  output logic [WB_N-1:0]          wb_cyc,
  input  logic [WB_DW*WB_N-1:0]    wb_rdata,
  input  logic [WB_N-1:0]          wb_ack,
  output logic                     err_flag,
  output logic [31:0]              err_addr,
  output logic [1:0]               err_code,
  input  logic                     err_clr
);

  localparam int              WB_SW   = WB_DW / 8;
  localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - TO_W'(1);

  typedef enum logic [1:0] {IDLE, CYC, RESP} state_t;
  state_t state, state_nx;

  logic              ram_region, ram_ready_q, ram_spram_q;
  logic              wb_region, idx_ok, resp_q;
  logic              launch, dec_err, timeout, ack_hit;
  logic [3:0]        idx_q;
  logic [31:0]       addr_q, rdata_q, sel_rd, ram_rd;
  logic [WB_N-1:0]   sel_oh;
  logic [TO_W-1:0]   to_cnt;

  // RAM side is a pass-through; the RAMs register the read, so ready follows one cycle later
  assign ram_region  = pb_valid & ~pb_addr[31];
  assign bram_addr   = pb_addr[RAM_AW+1:2];
  assign bram_wdata  = pb_wdata;
  assign bram_wmsk   = ~pb_wstrb;
  assign bram_we     = ram_region & ~pb_addr[17] & (|pb_wstrb);
  assign spram_addr  = pb_addr[RAM_AW+1:2];
  assign spram_wdata = pb_wdata;
  assign spram_wmsk  = ~pb_wstrb;
  assign spram_we    = ram_region & pb_addr[17] & (|pb_wstrb);
  assign ram_rd      = ram_spram_q ? spram_rdata : bram_rdata;

  assign wb_region = pb_valid & pb_addr[31];
  assign idx_ok    = {1'b0, pb_addr[27:24]} < 5'(WB_N);

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    dec_err  = 1'b0;
    timeout  = 1'b0;
    sel_oh   = WB_N'(1) << idx_q;
    ack_hit  = |(wb_ack & sel_oh);
    sel_rd   = '0;
    sel_rd[WB_DW-1:0] = wb_rdata[int'(idx_q)*WB_DW +: WB_DW];
    case (state)
      IDLE: begin
        // resp_q keeps a still-held pb_valid from relaunching right after a response
        if (wb_region && !resp_q) begin
          if (idx_ok) begin
            launch   = 1'b1;
            state_nx = CYC;
          end else begin
            dec_err  = 1'b1;
            state_nx = RESP;
          end
        end
      end
      CYC: begin
        if (ack_hit) begin
          state_nx = RESP;
        end else if (to_cnt == TO_LAST) begin
          timeout  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign wb_cyc   = (state == CYC) ? sel_oh : '0;
  assign pb_ready = ram_ready_q | (state == RESP);
  assign pb_rdata = ram_ready_q ? ram_rd : ((state == RESP) ? rdata_q : 32'h0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      resp_q      <= 1'b0;
      ram_ready_q <= 1'b0;
      ram_spram_q <= 1'b0;
      idx_q       <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      to_cnt      <= '0;
      wb_addr     <= '0;
      wb_wdata    <= '0;
      wb_wmsk     <= '0;
      wb_we       <= 1'b0;
      err_flag    <= 1'b0;
      err_addr    <= '0;
      err_code    <= '0;
    end else begin
      state       <= state_nx;
      resp_q      <= (state == RESP);
      ram_ready_q <= ram_region & ~ram_ready_q;
      ram_spram_q <= pb_addr[17];
      to_cnt      <= (state == CYC && state_nx == CYC) ? to_cnt + TO_W'(1) : '0;
      if (launch) begin
        idx_q    <= pb_addr[27:24];
        addr_q   <= pb_addr;
        wb_addr  <= pb_addr[WB_AW+WB_AI-1:WB_AI];
        wb_wdata <= pb_wdata[WB_DW-1:0];
        wb_wmsk  <= ~pb_wstrb[WB_SW-1:0];
        wb_we    <= |pb_wstrb;
      end
      if (state == CYC && ack_hit) rdata_q <= sel_rd;
      if (timeout || dec_err)      rdata_q <= ERR_DATA;
      // a new error beats a simultaneous clear; otherwise only the first error sticks
      if ((timeout || dec_err) && (!err_flag || err_clr)) begin
        err_flag <= 1'b1;
        err_addr <= dec_err ? pb_addr : addr_q;
        err_code <= dec_err ? 2'b10 : 2'b01;
      end else if (err_clr) begin
        err_flag <= 1'b0;
        err_addr <= '0;
        err_code <= '0;
      end
    end
  end

endmodule

// File: tb/tb_soc_picorv32_xbar.sv
// Directed bench for soc_picorv32_xbar: RAM paths, Wishbone read/write, timeout, decode error,
// error latch/clear interplay and reset during a bus cycle.
module tb_soc_picorv32_xbar;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  pb_addr, pb_wdata, pb_rdata;
  logic [3:0]   pb_wstrb;
  logic         pb_valid, pb_ready;
  logic [14:0]  bram_addr, spram_addr;
  logic [31:0]  bram_wdata, spram_wdata, bram_rdata, spram_rdata;
  logic [3:0]   bram_wmsk, spram_wmsk;
  logic         bram_we, spram_we;
  logic [15:0]  wb_addr;
  logic [31:0]  wb_wdata;
  logic [3:0]   wb_wmsk;
  logic         wb_we;
  logic [7:0]   wb_cyc, wb_ack;
  logic [255:0] wb_rdata;
  logic         err_flag, err_clr;
  logic [31:0]  err_addr;
  logic [1:0]   err_code;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] bmem [0:15];
  logic [31:0] smem [0:15];

  always #5 clk = ~clk;

  soc_picorv32_xbar dut (
    .clk(clk), .rst_n(rst_n),
    .pb_addr(pb_addr), .pb_wdata(pb_wdata), .pb_wstrb(pb_wstrb), .pb_valid(pb_valid),
    .pb_rdata(pb_rdata), .pb_ready(pb_ready),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_wmsk(bram_wmsk), .bram_we(bram_we),
    .bram_rdata(bram_rdata),
    .spram_addr(spram_addr), .spram_wdata(spram_wdata), .spram_wmsk(spram_wmsk), .spram_we(spram_we),
    .spram_rdata(spram_rdata),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wmsk(wb_wmsk), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .wb_rdata(wb_rdata), .wb_ack(wb_ack),
    .err_flag(err_flag), .err_addr(err_addr), .err_code(err_code), .err_clr(err_clr)
  );

  // synchronous RAM models with distinct fill patterns so the read mux is observable
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        bmem[i] <= 32'hB000_0000 + 32'(i);
        smem[i] <= 32'h5000_0000 + 32'(i);
      end
    end else begin
      if (bram_we)  bmem[bram_addr[3:0]]  <= bram_wdata;
      if (spram_we) smem[spram_addr[3:0]] <= spram_wdata;
    end
    bram_rdata  <= bmem[bram_addr[3:0]];
    spram_rdata <= smem[spram_addr[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int  cnt;
  bit  seen;
  logic [31:0] rd_at_ready;
  logic [7:0]  cyc_at_ready;

  initial begin
    rst_n = 1'b0; pb_addr = '0; pb_wdata = '0; pb_wstrb = '0; pb_valid = 1'b0;
    wb_ack = '0; wb_rdata = '0; err_clr = 1'b0;
    wb_rdata[1*32 +: 32] = 32'h0000_0077;
    wb_rdata[3*32 +: 32] = 32'hCAFE_F00D;
    wb_rdata[5*32 +: 32] = 32'h1111_1111;
    idle(3);
    chk("rst_ready", 32'(pb_ready), 32'h0);
    chk("rst_rdata", pb_rdata, 32'h0);
    chk("rst_cyc", 32'(wb_cyc), 32'h0);
    chk("rst_err_flag", 32'(err_flag), 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_code", 32'(err_code), 32'h0);
    chk("rst_wb_addr", 32'(wb_addr), 32'h0);
    chk("rst_wb_we", 32'(wb_we), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // BRAM write then read
    pb_valid = 1'b1; pb_addr = 32'h0000_0010; pb_wdata = 32'h1234_5678; pb_wstrb = 4'hF;
    #1;
    chk("bram_wr_we", 32'(bram_we), 32'h1);
    chk("bram_wr_spram_we", 32'(spram_we), 32'h0);
    chk("bram_wr_addr", 32'(bram_addr), 32'h4);
    chk("bram_wr_wmsk", 32'(bram_wmsk), 32'h0);
    chk("bram_wr_ready0", 32'(pb_ready), 32'h0);
    @(negedge clk);
    chk("bram_wr_ready1", 32'(pb_ready), 32'h1);
    pb_valid = 1'b0; pb_wstrb = 4'h0;
    @(negedge clk);
    chk("bram_wr_ready_pulse", 32'(pb_ready), 32'h0);
    chk("rdata_zero_idle", pb_rdata, 32'h0);
    pb_valid = 1'b1; pb_addr = 32'h0000_0010;
    #1;
    chk("bram_rd_we", 32'(bram_we), 32'h0);
    @(negedge clk);
    chk("bram_rd_ready", 32'(pb_ready), 32'h1);
    chk("bram_rd_data", pb_rdata, 32'h1234_5678);
    pb_valid = 1'b0;
    idle(1);

    // SPRAM write then read, plus an untouched SPRAM word
    pb_valid = 1'b1; pb_addr = 32'h0002_0010; pb_wdata = 32'h1234_5678; pb_wstrb = 4'hF;
    #1;
    chk("spram_wr_we", 32'(spram_we), 32'h1);
    chk("spram_wr_bram_we", 32'(bram_we), 32'h0);
    chk("spram_wr_addr", 32'(spram_addr), 32'h4);
    @(negedge clk);
    chk("spram_wr_ready", 32'(pb_ready), 32'h1);
    pb_valid = 1'b0; pb_wstrb = 4'h0;
    idle(1);
    pb_valid = 1'b1; pb_addr = 32'h0002_0010;
    @(negedge clk);
    chk("spram_rd_data", pb_rdata, 32'h1234_5678);
    pb_valid = 1'b0;
    idle(1);
    pb_valid = 1'b1; pb_addr = 32'h0002_0014;
    @(negedge clk);
    chk("spram_rd_pattern", pb_rdata, 32'h5000_0005);
    pb_valid = 1'b0;
    idle(1);

    // WB read from slave 3, ack three cycles after cyc, stray ack on slave 5
    pb_valid = 1'b1; pb_addr = 32'h8300_0004; pb_wstrb = 4'h0;
    #1;
    chk("wb3_cyc_c0", 32'(wb_cyc), 32'h0);
    @(negedge clk);
    chk("wb3_cyc_c1", 32'(wb_cyc), 32'h08);
    chk("wb3_addr", 32'(wb_addr), 32'h1);
    chk("wb3_we", 32'(wb_we), 32'h0);
    chk("wb3_ready_c1", 32'(pb_ready), 32'h0);
    wb_ack = 8'h20;
    @(negedge clk);
    chk("wb3_cyc_c2", 32'(wb_cyc), 32'h08);
    wb_ack = 8'h00;
    @(negedge clk);
    chk("wb3_cyc_c3", 32'(wb_cyc), 32'h08);
    chk("wb3_ready_c3", 32'(pb_ready), 32'h0);
    wb_ack = 8'h08;
    @(negedge clk);
    chk("wb3_ready", 32'(pb_ready), 32'h1);
    chk("wb3_rdata", pb_rdata, 32'hCAFE_F00D);
    chk("wb3_cyc_dropped", 32'(wb_cyc), 32'h0);
    wb_ack = 8'h00; pb_valid = 1'b0;
    @(negedge clk);
    chk("wb3_ready_once", 32'(pb_ready), 32'h0);
    chk("wb3_rdata_zero", pb_rdata, 32'h0);
    idle(1);

    // zero-wait WB write to slave 1: ready two cycles after valid
    pb_valid = 1'b1; pb_addr = 32'h8100_0008; pb_wdata = 32'hA5A5_A5A5; pb_wstrb = 4'h3; wb_ack = 8'h02;
    @(negedge clk);
    chk("wb1_cyc", 32'(wb_cyc), 32'h02);
    chk("wb1_we", 32'(wb_we), 32'h1);
    chk("wb1_wmsk", 32'(wb_wmsk), 32'hC);
    chk("wb1_wdata", wb_wdata, 32'hA5A5_A5A5);
    chk("wb1_addr", 32'(wb_addr), 32'h2);
    chk("wb1_ready_c1", 32'(pb_ready), 32'h0);
    @(negedge clk);
    chk("wb1_ready_c2", 32'(pb_ready), 32'h1);
    chk("wb1_rdata", pb_rdata, 32'h0000_0077);
    pb_valid = 1'b0; wb_ack = 8'h00;
    idle(2);

    // WB write timeout on slave 1; pb_valid dropped mid-cycle must not abort it
    pb_valid = 1'b1; pb_addr = 32'h8100_0000; pb_wdata = 32'h0; pb_wstrb = 4'hF;
    cnt = 0; seen = 1'b0; rd_at_ready = '0; cyc_at_ready = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 10) pb_valid = 1'b0;
      if (pb_ready) begin
        seen = 1'b1; rd_at_ready = pb_rdata; cyc_at_ready = wb_cyc;
        break;
      end
      if (wb_cyc == 8'h02) cnt++;
    end
    pb_valid = 1'b0;
    chk("to_ready_seen", 32'(seen), 32'h1);
    chk("to_cyc_cycles", 32'(cnt), 32'd255);
    chk("to_rdata", rd_at_ready, 32'hDEAD_BEEF);
    chk("to_cyc_at_ready", 32'(cyc_at_ready), 32'h0);
    chk("to_err_flag", 32'(err_flag), 32'h1);
    chk("to_err_code", 32'(err_code), 32'h1);
    chk("to_err_addr", err_addr, 32'h8100_0000);
    idle(2);

    // decode error while an error is already latched: response happens, latch untouched
    pb_valid = 1'b1; pb_addr = 32'h8F00_0000; pb_wstrb = 4'h0;
    #1;
    chk("dec1_cyc_c0", 32'(wb_cyc), 32'h0);
    @(negedge clk);
    chk("dec1_ready", 32'(pb_ready), 32'h1);
    chk("dec1_rdata", pb_rdata, 32'hDEAD_BEEF);
    chk("dec1_cyc", 32'(wb_cyc), 32'h0);
    chk("dec1_keep_addr", err_addr, 32'h8100_0000);
    chk("dec1_keep_code", 32'(err_code), 32'h1);
    pb_valid = 1'b0;
    idle(2);

    // err_clr alone
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_flag", 32'(err_flag), 32'h0);
    chk("clr_addr", err_addr, 32'h0);
    chk("clr_code", 32'(err_code), 32'h0);

    // decode error on a clean latch
    pb_valid = 1'b1; pb_addr = 32'h8F00_0000;
    @(negedge clk);
    chk("dec2_ready", 32'(pb_ready), 32'h1);
    chk("dec2_flag", 32'(err_flag), 32'h1);
    chk("dec2_code", 32'(err_code), 32'h2);
    chk("dec2_addr", err_addr, 32'h8F00_0000);
    pb_valid = 1'b0;
    idle(2);

    // timeout on slave 2 with err_clr in the timeout cycle: the new error wins
    pb_valid = 1'b1; pb_addr = 32'h8200_0010; pb_wstrb = 4'h0;
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pb_ready) begin
        seen = 1'b1;
        break;
      end
      if (wb_cyc == 8'h04) cnt++;
      if (cnt == 255) err_clr = 1'b1;
    end
    err_clr = 1'b0; pb_valid = 1'b0;
    chk("clrwin_ready_seen", 32'(seen), 32'h1);
    chk("clrwin_flag", 32'(err_flag), 32'h1);
    chk("clrwin_addr", err_addr, 32'h8200_0010);
    chk("clrwin_code", 32'(err_code), 32'h1);
    idle(2);

    // reset while slave 2 cycle is open
    pb_valid = 1'b1; pb_addr = 32'h8200_0000;
    @(negedge clk);
    chk("rstcyc_cyc_open", 32'(wb_cyc), 32'h04);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstcyc_cyc", 32'(wb_cyc), 32'h0);
    chk("rstcyc_ready", 32'(pb_ready), 32'h0);
    chk("rstcyc_rdata", pb_rdata, 32'h0);
    chk("rstcyc_err_flag", 32'(err_flag), 32'h0);
    chk("rstcyc_err_addr", err_addr, 32'h0);
    chk("rstcyc_wb_addr", 32'(wb_addr), 32'h0);
    pb_valid = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pb_ready) seen = 1'b1;
    end
    chk("rstcyc_no_ready", 32'(seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_picorv32_xbar.md
SOC_PICORV32_XBAR -- requirements
Module: soc_picorv32_xbar

Interface
REQ-001 SHALL have parameter WB_N, default 8: number of Wishbone slaves, 1..16.
REQ-002 SHALL have parameter WB_DW, default 32: Wishbone data width, 8/16/32.
REQ-003 SHALL have parameter WB_AW, default 16: Wishbone word-address width.
REQ-004 SHALL have parameter WB_AI, default 2: lowest pb_addr bit mapped to wb_addr[0].
REQ-005 SHALL have parameter RAM_AW, default 15: BRAM/SPRAM word-address width.
REQ-006 SHALL have parameter TO_W, default 8: timeout counter width.
REQ-007 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: read data returned on error.
REQ-008 SHALL have ports clk in 1 (single clock) and rst_n in 1, where rst_n is synchronous, active-low.
REQ-009 SHALL have PicoRV32 ports pb_addr in 32, pb_wdata in 32, pb_wstrb in 4, pb_valid in 1, pb_rdata out 32, pb_ready out 1.
REQ-010 SHALL have BRAM ports bram_addr out RAM_AW, bram_wdata out 32, bram_wmsk out 4, bram_we out 1, bram_rdata in 32.
REQ-011 SHALL have SPRAM ports spram_addr, spram_wdata, spram_wmsk, spram_we, spram_rdata with the same widths and directions as the BRAM ports.
REQ-012 SHALL have Wishbone ports wb_addr out WB_AW, wb_wdata out WB_DW, wb_wmsk out WB_DW/8, wb_we out 1, wb_cyc out WB_N, wb_rdata in WB_DW*WB_N, wb_ack in WB_N.
REQ-013 SHALL have error ports err_flag out 1, err_addr out 32, err_code out 2, err_clr in 1.

Function
REQ-014 SHALL decode the RAM region as pb_addr[31]=0, with pb_addr[17]=0 selecting BRAM and pb_addr[17]=1 selecting SPRAM; RAM addr = pb_addr[RAM_AW+1:2], wdata = pb_wdata, wmsk = ~pb_wstrb, we = valid & region & |pb_wstrb.
REQ-015 SHALL assert pb_ready for a RAM access 1 cycle after pb_valid, as a single-cycle pulse, with pb_rdata = the selected RAM rdata in that cycle.
REQ-016 SHALL decode Wishbone as pb_addr[31]=1, slave index = pb_addr[27:24].
REQ-017 SHALL use FSM states IDLE, CYC, RESP.
REQ-018 IDLE: on a WB-region pb_valid with index < WB_N, SHALL register wb_addr=pb_addr[WB_AW+WB_AI-1:WB_AI], wb_wdata, wb_wmsk=~pb_wstrb[WB_DW/8-1:0], wb_we=|pb_wstrb, and go to CYC.
REQ-019 CYC: SHALL assert only wb_cyc[index] and hold all wb_* outputs stable.
REQ-020 CYC: SHALL increment the timeout counter each cycle without ack.
REQ-021 CYC with wb_ack[index]=1 SHALL capture wb_rdata[index] (zero-extended to 32 bits), drop wb_cyc the following cycle and go to RESP.
REQ-022 A wb_ack on a slave other than index SHALL be ignored.
REQ-023 When the timeout counter reaches 2^TO_W-1 with no ack, SHALL drop wb_cyc, load ERR_DATA, set err_code=2'b01 (timeout) and go to RESP.
REQ-024 IDLE with WB-region pb_valid and index >= WB_N SHALL go directly to RESP with ERR_DATA, err_code=2'b10 (decode), and no wb_cyc asserted.
REQ-025 RESP: SHALL pulse pb_ready for 1 cycle with pb_rdata = captured data (reads and writes alike), then go to IDLE.
REQ-026 A zero-wait slave SHALL give pb_ready exactly 2 cycles after pb_valid.
REQ-027 IDLE SHALL not launch a new access in the cycle immediately after RESP.
REQ-028 pb_rdata SHALL be 0 whenever pb_ready=0.
REQ-029 On timeout or decode error, SHALL set err_flag=1 and latch err_addr=pb_addr.
REQ-030 Only the first error SHALL be latched while err_flag=1.
REQ-031 err_clr SHALL clear err_flag, err_addr and err_code in 1 cycle; an error in the same cycle as err_clr wins and is latched.
REQ-032 A pb_valid drop while in CYC SHALL not abort the cycle; the transaction completes and the pb_ready pulse is still issued.

Reset
REQ-033 With rst_n=0 at a clk edge, SHALL set FSM=IDLE, wb_cyc=0, pb_ready=0, pb_rdata=0, timeout counter=0, err_flag=0, err_addr=0, err_code=0, and all registered wb_* outputs =0.
REQ-034 Reset asserted mid-CYC SHALL drop wb_cyc on that edge with no pb_ready issued.

Verification
REQ-035 Test BRAM write then read: write 0x12345678 to 0x00000010 with wstrb=0xF, then read -> bram_we pulse, ready at +1 cycle, rdata 0x12345678; repeat via 0x00020010 so the write and read go to SPRAM.
REQ-036 Test WB read from slave 3: read 0x83000004, ack 3 cycles after cyc with rdata 0xCAFEF00D -> wb_addr=1, only wb_cyc[3] set, pb_ready once, pb_rdata=0xCAFEF00D.
REQ-037 Test WB write timeout: write to 0x81000000 with no ack -> cyc dropped after 255 cycles, pb_ready pulse, err_flag=1, err_code=01, err_addr=0x81000000.
REQ-038 Test decode error: read 0x8F000000 with WB_N=8 -> no wb_cyc, ready at +1, rdata 0xDEADBEEF, err_code=10.
REQ-039 Test simultaneous error and err_clr: err_clr asserted in the same cycle as a new timeout -> err_flag stays 1 with the new err_addr.
REQ-040 Test reset during CYC: rst_n=0 while wb_cyc[2]=1 -> wb_cyc=0 next edge, no pb_ready, all outputs at reset values.
